// File: rtl/cache_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_req_arbiter_if
// Purpose  : Bundles the CPU request, snoop request, cache-controller and
//            forwarding signals of the cache request arbiter.
// Ports    : none (signal container)
//   master : requester / controller side (drives requests and ctrl status)
//   slave  : arbiter side (drives readies, forward and done signals)
// Revision : 1.0 - initial release
// ============================================================================
interface cache_req_arbiter_if;
  logic       cpu_valid;
  logic [1:0] cpu_request;
  logic       cpu_ready;
  logic       snoop_valid;
  logic [1:0] snoop_type;
  logic       snoop_ready;
  logic       ctrl_ready;
  logic       ctrl_complete;
  logic       fwd_valid;
  logic       fwd_is_snoop;
  logic [1:0] fwd_op;
  logic       cpu_done;
  logic       snoop_done;
  logic       busy;

  modport master (
    output cpu_valid, cpu_request, snoop_valid, snoop_type,
    output ctrl_ready, ctrl_complete,
    input  cpu_ready, snoop_ready, fwd_valid, fwd_is_snoop, fwd_op,
    input  cpu_done, snoop_done, busy
  );

  modport slave (
    input  cpu_valid, cpu_request, snoop_valid, snoop_type,
    input  ctrl_ready, ctrl_complete,
    output cpu_ready, snoop_ready, fwd_valid, fwd_is_snoop, fwd_op,
    output cpu_done, snoop_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_req_arbiter
// Purpose  : Arbitrates between CPU requests and interconnect snoops for a
//            single cache controller. Snoops win by default; one operation
//            is in flight at a time (grant -> issue -> wait for completion).
// Ports    : clk_i    - clock, rising edge
//            reset_ni - asynchronous active-low reset
//            bus      - cache_req_arbiter_if.slave (requests, readies,
//                       forward channel, done pulses, busy)
// Config   : `define STARVE_GUARD_EN to cap consecutive snoop grants at
//            MAX_SNOOP_BURST while a CPU request waits.
// Revision : 1.0 - initial release
// ============================================================================
module cache_req_arbiter #(
  parameter int MAX_SNOOP_BURST = 4,
  parameter int WIDTH_CNT       = 4
) (
  input  wire logic             clk_i,
  input  wire logic             reset_ni,
  cache_req_arbiter_if.slave    bus
);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_CPU_ISSUE   = 2'd1;
  localparam logic [1:0] S_SNOOP_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT_DONE   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] fwd_op_q, fwd_op_d;
  logic       fwd_is_snoop_q, fwd_is_snoop_d;
  logic       cpu_done_q, cpu_done_d;
  logic       snoop_done_q, snoop_done_d;

  logic cpu_pend, snoop_pend, starve;
  logic grant_cpu, grant_snoop;

  // Codes 10/11 are never CPU work, 11 is never a snoop.
  assign cpu_pend   = bus.cpu_valid & ~bus.cpu_request[1];
  assign snoop_pend = bus.snoop_valid & (bus.snoop_type != 2'b11);

`ifdef STARVE_GUARD_EN
  logic [WIDTH_CNT-1:0] burst_cnt_q, burst_cnt_d;

  // Counter only advances while a CPU request is actually being passed over,
  // so it can never run past MAX_SNOOP_BURST.
  assign starve = (burst_cnt_q == WIDTH_CNT'(MAX_SNOOP_BURST));

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (grant_cpu)
      burst_cnt_d = '0;
    else if (grant_snoop && cpu_pend)
      burst_cnt_d = burst_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) burst_cnt_q <= '0;
    else           burst_cnt_q <= burst_cnt_d;
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(MAX_SNOOP_BURST) ^ 32'(WIDTH_CNT);
  assign starve     = 1'b0;
`endif

  // Arbitration: only IDLE with an idle controller may grant.
  always_comb begin
    grant_cpu   = 1'b0;
    grant_snoop = 1'b0;
    if (state_q == S_IDLE && bus.ctrl_ready) begin
      grant_cpu   = cpu_pend & (~snoop_pend | starve);
      grant_snoop = snoop_pend & ~grant_cpu;
    end
  end

  // State register and latched operation / done pulses.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= S_IDLE;
      fwd_op_q       <= 2'b00;
      fwd_is_snoop_q <= 1'b0;
      cpu_done_q     <= 1'b0;
      snoop_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      fwd_op_q       <= fwd_op_d;
      fwd_is_snoop_q <= fwd_is_snoop_d;
      cpu_done_q     <= cpu_done_d;
      snoop_done_q   <= snoop_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d        = state_q;
    fwd_op_d       = fwd_op_q;
    fwd_is_snoop_d = fwd_is_snoop_q;
    cpu_done_d     = 1'b0;
    snoop_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_cpu) begin
          state_d        = S_CPU_ISSUE;
          fwd_op_d       = bus.cpu_request;
          fwd_is_snoop_d = 1'b0;
        end else if (grant_snoop) begin
          state_d        = S_SNOOP_ISSUE;
          fwd_op_d       = bus.snoop_type;
          fwd_is_snoop_d = 1'b1;
        end
      end
      S_CPU_ISSUE, S_SNOOP_ISSUE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // Done pulses are registered so they land in the first IDLE cycle.
        if (bus.ctrl_complete) begin
          state_d      = S_IDLE;
          cpu_done_d   = ~fwd_is_snoop_q;
          snoop_done_d = fwd_is_snoop_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.cpu_ready    = grant_cpu;
    bus.snoop_ready  = grant_snoop;
    bus.fwd_valid    = (state_q == S_CPU_ISSUE) || (state_q == S_SNOOP_ISSUE);
    bus.busy         = (state_q != S_IDLE);
    bus.fwd_op       = fwd_op_q;
    bus.fwd_is_snoop = fwd_is_snoop_q;
    bus.cpu_done     = cpu_done_q;
    bus.snoop_done   = snoop_done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_req_arbiter
// Purpose  : Self-checking bench for cache_req_arbiter: directed scenarios
//            plus randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_req_arbiter;
  localparam int MAX = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cache_req_arbiter_if bus();

  cache_req_arbiter #(.MAX_SNOOP_BURST(MAX), .WIDTH_CNT(4)) dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .bus     (bus.slave)
  );

  task automatic step(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk); endtask

  task automatic idle_inputs();
    bus.cpu_valid = 0; bus.cpu_request = 2'b11;
    bus.snoop_valid = 0; bus.snoop_type = 2'b11;
    bus.ctrl_ready = 1; bus.ctrl_complete = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    smp(); smp();
    n_tests++;
    if ({bus.busy, bus.fwd_valid, bus.cpu_done, bus.snoop_done, bus.fwd_is_snoop, bus.fwd_op} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b fv=%b cd=%b sd=%b snp=%b op=%b, want all 0",
               bus.busy, bus.fwd_valid, bus.cpu_done, bus.snoop_done, bus.fwd_is_snoop, bus.fwd_op);
    end
    step(); reset_n = 1;
  endtask

  task automatic test_cpu_read();
    do_reset();
    bus.cpu_valid = 1; bus.cpu_request = 2'b00;
    smp(); n_tests++;
    if ({bus.cpu_ready, bus.snoop_ready} !== 2'b10) begin
      n_fail++; $display("FAIL cpu_read_ready: got %b%b want 10", bus.cpu_ready, bus.snoop_ready);
    end
    step(); bus.cpu_valid = 0;
    smp(); n_tests++;
    if ({bus.fwd_valid, bus.fwd_op, bus.fwd_is_snoop, bus.busy} !== 5'b1_00_0_1) begin
      n_fail++; $display("FAIL cpu_read_fwd: got fv=%b op=%b snp=%b busy=%b want 1 00 0 1",
                         bus.fwd_valid, bus.fwd_op, bus.fwd_is_snoop, bus.busy);
    end
    step(); step(); smp(); n_tests++;
    if ({bus.fwd_valid, bus.busy, bus.cpu_done} !== 3'b010) begin
      n_fail++; $display("FAIL cpu_read_wait: got fv=%b busy=%b cd=%b want 0 1 0", bus.fwd_valid, bus.busy, bus.cpu_done);
    end
    step(); bus.ctrl_complete = 1;
    step(); bus.ctrl_complete = 0;
    smp(); n_tests++;
    if ({bus.cpu_done, bus.snoop_done, bus.busy} !== 3'b100) begin
      n_fail++; $display("FAIL cpu_read_done: got cd=%b sd=%b busy=%b want 1 0 0", bus.cpu_done, bus.snoop_done, bus.busy);
    end
    step(); smp(); n_tests++;
    if (bus.cpu_done !== 1'b0) begin
      n_fail++; $display("FAIL cpu_done_pulse: got %b want 0", bus.cpu_done);
    end
  endtask

  task automatic test_snoop_priority();
    do_reset();
    bus.cpu_valid = 1; bus.cpu_request = 2'b01;
    bus.snoop_valid = 1; bus.snoop_type = 2'b10;
    smp(); n_tests++;
    if ({bus.snoop_ready, bus.cpu_ready} !== 2'b10) begin
      n_fail++; $display("FAIL snoop_prio_ready: got snp=%b cpu=%b want 1 0", bus.snoop_ready, bus.cpu_ready);
    end
    step(); bus.snoop_valid = 0;
    smp(); n_tests++;
    if ({bus.fwd_valid, bus.fwd_op, bus.fwd_is_snoop, bus.cpu_ready} !== 5'b1_10_1_0) begin
      n_fail++; $display("FAIL snoop_prio_fwd: got fv=%b op=%b snp=%b crdy=%b want 1 10 1 0",
                         bus.fwd_valid, bus.fwd_op, bus.fwd_is_snoop, bus.cpu_ready);
    end
    step(); bus.ctrl_complete = 1;
    step(); bus.ctrl_complete = 0;
    smp(); n_tests++;
    // Completion pulse and the next grant share the first IDLE cycle.
    if ({bus.snoop_done, bus.cpu_done, bus.cpu_ready} !== 3'b101) begin
      n_fail++; $display("FAIL done_and_ready: got sd=%b cd=%b crdy=%b want 1 0 1", bus.snoop_done, bus.cpu_done, bus.cpu_ready);
    end
    step(); bus.cpu_valid = 0;
    smp(); n_tests++;
    if ({bus.fwd_valid, bus.fwd_op, bus.fwd_is_snoop} !== 4'b1_01_0) begin
      n_fail++; $display("FAIL cpu_after_snoop: got fv=%b op=%b snp=%b want 1 01 0", bus.fwd_valid, bus.fwd_op, bus.fwd_is_snoop);
    end
    step(); bus.ctrl_complete = 1;
    step(); bus.ctrl_complete = 0;
    smp(); n_tests++;
    if ({bus.cpu_done, bus.fwd_op, bus.fwd_is_snoop} !== 4'b1_01_0) begin
      n_fail++; $display("FAIL cpu_write_done: got cd=%b op=%b snp=%b want 1 01 0", bus.cpu_done, bus.fwd_op, bus.fwd_is_snoop);
    end
  endtask

  task automatic test_invalid_codes();
    do_reset();
    bus.cpu_valid = 1;
    bus.snoop_valid = 1; bus.snoop_type = 2'b11;
    for (int i = 0; i < 10; i++) begin
      bus.cpu_request = (i % 2 == 0) ? 2'b11 : 2'b10;
      smp(); n_tests++;
      if ({bus.cpu_ready, bus.snoop_ready, bus.busy} !== 3'b000) begin
        n_fail++; $display("FAIL invalid_code cyc%0d: got crdy=%b srdy=%b busy=%b want 000",
                           i, bus.cpu_ready, bus.snoop_ready, bus.busy);
      end
      step();
    end
  endtask

  task automatic test_ctrl_not_ready();
    do_reset();
    bus.cpu_valid = 1; bus.cpu_request = 2'b00;
    bus.snoop_valid = 1; bus.snoop_type = 2'b01;
    bus.ctrl_ready = 0;
    for (int i = 0; i < 5; i++) begin
      smp(); n_tests++;
      if ({bus.cpu_ready, bus.snoop_ready, bus.busy} !== 3'b000) begin
        n_fail++; $display("FAIL ctrl_not_ready cyc%0d: got crdy=%b srdy=%b busy=%b want 000",
                           i, bus.cpu_ready, bus.snoop_ready, bus.busy);
      end
      step();
    end
    bus.ctrl_ready = 1;
    smp(); n_tests++;
    if ({bus.snoop_ready, bus.cpu_ready} !== 2'b10) begin
      n_fail++; $display("FAIL ctrl_ready_grant: got srdy=%b crdy=%b want 1 0", bus.snoop_ready, bus.cpu_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    bus.cpu_valid = 1; bus.cpu_request = 2'b00;
    step(); bus.cpu_valid = 0;
    step(); smp(); n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL wait_busy: got %b want 1", bus.busy);
    end
    step(); reset_n = 0;
    smp(); n_tests++;
    if ({bus.busy, bus.cpu_done, bus.fwd_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_op: got busy=%b cd=%b fv=%b want 000", bus.busy, bus.cpu_done, bus.fwd_valid);
    end
    step(); reset_n = 1; bus.ctrl_complete = 1;
    step(); bus.ctrl_complete = 0;
    smp(); n_tests++;
    if ({bus.busy, bus.cpu_done, bus.snoop_done} !== 3'b000) begin
      n_fail++; $display("FAIL stale_complete: got busy=%b cd=%b sd=%b want 000", bus.busy, bus.cpu_done, bus.snoop_done);
    end
  endtask

  task automatic test_starvation();
    bit exp_seq [6];
    bit got_seq [6];
    int n = 0;
    do_reset();
`ifdef STARVE_GUARD_EN
    exp_seq = '{1, 1, 0, 1, 1, 0};
`else
    exp_seq = '{1, 1, 1, 1, 1, 1};
`endif
    bus.cpu_valid = 1; bus.cpu_request = 2'b00;
    bus.snoop_valid = 1; bus.snoop_type = 2'b00;
    bus.ctrl_complete = 1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      smp();
      if (bus.cpu_ready || bus.snoop_ready) begin
        got_seq[n] = bus.snoop_ready;
        n++;
      end
      step();
    end
    n_tests++;
    if (n != 6) begin
      n_fail++; $display("FAIL starve_grants: got %0d grants want 6", n);
    end
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (got_seq[i] !== exp_seq[i]) begin
        n_fail++; $display("FAIL starve_order grant%0d: got snoop=%b want %b", i, got_seq[i], exp_seq[i]);
      end
    end
    idle_inputs();
  endtask

  // Transaction-level reference: one operation at a time; age counts cycles
  // since its grant (1 = presented to the controller, >=2 = awaiting completion).
  task automatic test_random();
    bit in_flight = 0, org_snoop = 0, lat_snoop = 0, pend_cd = 0, pend_sd = 0;
    int age = 0, burst = 0;
    logic [1:0] lat_op = 2'b00;
    bit rst, cp, sp, win_cpu, win_snp, guard;
`ifdef STARVE_GUARD_EN
    guard = 1;
`else
    guard = 0;
`endif
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(99) == 0);
      reset_n = ~rst;
      bus.cpu_valid = $urandom_range(1); bus.cpu_request = 2'($urandom_range(3));
      bus.snoop_valid = $urandom_range(1); bus.snoop_type = 2'($urandom_range(3));
      bus.ctrl_ready = ($urandom_range(9) < 7);
      bus.ctrl_complete = ($urandom_range(9) < 4);
      cp = bus.cpu_valid && (bus.cpu_request inside {2'b00, 2'b01});
      sp = bus.snoop_valid && (bus.snoop_type != 2'b11);
      win_cpu = 0; win_snp = 0;
      if (rst) begin
        in_flight = 0; lat_op = 0; lat_snoop = 0; pend_cd = 0; pend_sd = 0; burst = 0;
      end else if (!in_flight && bus.ctrl_ready) begin
        win_cpu = cp && (!sp || (guard && burst == MAX));
        win_snp = sp && !win_cpu;
      end
      smp(); n_tests++;
      if ({bus.busy, bus.fwd_valid, bus.cpu_done, bus.snoop_done, bus.fwd_op, bus.fwd_is_snoop} !==
          {in_flight, in_flight && age == 1, pend_cd, pend_sd, lat_op, lat_snoop} ||
          (!rst && {bus.cpu_ready, bus.snoop_ready} !== {win_cpu, win_snp})) begin
        n_fail++;
        $display("FAIL random cyc%0d: got busy=%b fv=%b cd=%b sd=%b op=%b snp=%b crdy=%b srdy=%b want %b %b %b %b %b %b %b %b",
                 c, bus.busy, bus.fwd_valid, bus.cpu_done, bus.snoop_done, bus.fwd_op, bus.fwd_is_snoop,
                 bus.cpu_ready, bus.snoop_ready, in_flight, in_flight && age == 1, pend_cd, pend_sd,
                 lat_op, lat_snoop, win_cpu, win_snp);
      end
      if (!rst) begin
        pend_cd = 0; pend_sd = 0;
        if (in_flight) begin
          if (age >= 2 && bus.ctrl_complete) begin
            in_flight = 0; pend_cd = !org_snoop; pend_sd = org_snoop;
          end else age++;
        end else if (win_cpu || win_snp) begin
          in_flight = 1; age = 1; org_snoop = win_snp; lat_snoop = win_snp;
          lat_op = win_cpu ? bus.cpu_request : bus.snoop_type;
          if (win_cpu) burst = 0;
          else if (cp) burst++;
        end
      end
      step();
    end
    reset_n = 1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_snoop_priority();
    test_invalid_codes();
    test_ctrl_not_ready();
    test_reset_mid_op();
    test_starvation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
